// File: rtl/simplex8_pkg.sv
// Shared widths, opcodes and FSM encoding for the simplex8 program sequencer.
package simplex8_pkg;

  localparam int unsigned PC_W      = 8;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned FLAG_W    = 8;
  localparam int unsigned FLAG_IN_W = 7;
  localparam int unsigned IMM_W     = 4;
  localparam int unsigned RETIRED_W = 16;

  localparam logic [3:0] OP_JMP  = 4'hF;
  localparam logic [3:0] OP_HALT = 4'hE;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  // Instruction word layout: opcode, condition immediate, target/operand.
  typedef struct packed {
    logic [3:0]      opcode;
    logic [IMM_W-1:0] imm;
    logic [PC_W-1:0] operand;
  } instr_t;

endpackage

// File: rtl/cond_select.sv
// Jump condition: selects one flag by IMM[2:0] and optionally inverts it with IMM[3].
module cond_select
  import simplex8_pkg::*;
(
  input  logic [FLAG_W-1:0] flagreg,
  input  logic [IMM_W-1:0]  imm,
  output logic              cond
);

  // Flag bit 7 is tied high, so IMM=7 is "always" and IMM=F is "never".
  assign cond = flagreg[imm[2:0]] ^ imm[3];

endmodule

// File: rtl/program_sequencer.sv
// Fetch/decode/execute sequencer: owns PC, IR, flag register and retire count.
module program_sequencer
  import simplex8_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  output logic                 INSTR_REQ,
  output logic [PC_W-1:0]      INSTR_ADDR,
  input  logic                 INSTR_ACK,
  input  logic [INSTR_W-1:0]   INSTR_DATA,
  output logic                 EXEC_VALID,
  output logic [INSTR_W-1:0]   IR,
  input  logic                 EXEC_DONE,
  input  logic                 FLAGS_WE,
  input  logic [FLAG_IN_W-1:0] FLAGS_IN,
  output logic [PC_W-1:0]      PC,
  output logic                 JUMP_TAKEN,
  output logic                 HALTED,
  output logic [RETIRED_W-1:0] RETIRED
);

  state_t                 state, state_next;
  logic [PC_W-1:0]        pc_next;
  logic [INSTR_W-1:0]     ir_next;
  logic [RETIRED_W-1:0]   retired_next;
  logic                   retire;
  logic                   jump_next;
  logic [FLAG_IN_W-1:0]   flags_q;
  logic [FLAG_W-1:0]      flagreg;
  logic                   cond;
  instr_t                 ir_f;

  assign ir_f       = instr_t'(IR);
  assign flagreg    = {1'b1, flags_q};
  assign INSTR_ADDR = PC;

  cond_select u_cond_select (
    .flagreg (flagreg),
    .imm     (ir_f.imm),
    .cond    (cond)
  );

  // Flag register loads in every state; decode sees the value before this edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags_q <= '0;
    end else if (FLAGS_WE) begin
      flags_q <= FLAGS_IN;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_next = state;
    pc_next    = PC;
    ir_next    = IR;
    retire     = 1'b0;
    jump_next  = 1'b0;

    case (state)
      ST_FETCH: begin
        // Handshake only once the request is actually on the port.
        if (INSTR_REQ && INSTR_ACK) begin
          ir_next    = INSTR_DATA;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (ir_f.opcode == OP_JMP) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
          if (cond) begin
            pc_next   = ir_f.operand;
            jump_next = 1'b1;
          end else begin
            pc_next = PC + PC_W'(1);
          end
        end else if (ir_f.opcode == OP_HALT) begin
          retire     = 1'b1;
          state_next = ST_HALT;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (EXEC_DONE) begin
          pc_next    = PC + PC_W'(1);
          retire     = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase

    retired_next = RETIRED;
    if (retire && (RETIRED != {RETIRED_W{1'b1}})) begin
      retired_next = RETIRED + RETIRED_W'(1);
    end
  end

  // State register; status outputs are registered from the next state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= ST_FETCH;
      PC         <= '0;
      IR         <= '0;
      RETIRED    <= '0;
      JUMP_TAKEN <= 1'b0;
      INSTR_REQ  <= 1'b0;
      EXEC_VALID <= 1'b0;
      HALTED     <= 1'b0;
    end else begin
      state      <= state_next;
      PC         <= pc_next;
      IR         <= ir_next;
      RETIRED    <= retired_next;
      JUMP_TAKEN <= jump_next;
      INSTR_REQ  <= (state_next == ST_FETCH);
      EXEC_VALID <= (state_next == ST_EXEC);
      HALTED     <= (state_next == ST_HALT);
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with hand-computed expectations.
module tb_program_sequencer;

  logic        CLK;
  logic        RESET;
  logic        INSTR_REQ;
  logic [7:0]  INSTR_ADDR;
  logic        INSTR_ACK;
  logic [15:0] INSTR_DATA;
  logic        EXEC_VALID;
  logic [15:0] IR;
  logic        EXEC_DONE;
  logic        FLAGS_WE;
  logic [6:0]  FLAGS_IN;
  logic [7:0]  PC;
  logic        JUMP_TAKEN;
  logic        HALTED;
  logic [15:0] RETIRED;

  int n_tests = 0;
  int n_fail  = 0;

  program_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .INSTR_REQ  (INSTR_REQ),
    .INSTR_ADDR (INSTR_ADDR),
    .INSTR_ACK  (INSTR_ACK),
    .INSTR_DATA (INSTR_DATA),
    .EXEC_VALID (EXEC_VALID),
    .IR         (IR),
    .EXEC_DONE  (EXEC_DONE),
    .FLAGS_WE   (FLAGS_WE),
    .FLAGS_IN   (FLAGS_IN),
    .PC         (PC),
    .JUMP_TAKEN (JUMP_TAKEN),
    .HALTED     (HALTED),
    .RETIRED    (RETIRED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction in FETCH, then let DECODE resolve.
  task automatic issue(input logic [15:0] instr);
    INSTR_ACK  = 1'b1;
    INSTR_DATA = instr;
    tick();
    INSTR_ACK  = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"},   32'(PC),         32'h0);
    check({tag, "_addr"}, 32'(INSTR_ADDR), 32'h0);
    check({tag, "_ir"},   32'(IR),         32'h0);
    check({tag, "_ret"},  32'(RETIRED),    32'h0);
    check({tag, "_req"},  32'(INSTR_REQ),  32'h0);
    check({tag, "_ev"},   32'(EXEC_VALID), 32'h0);
    check({tag, "_halt"}, 32'(HALTED),     32'h0);
    check({tag, "_jmp"},  32'(JUMP_TAKEN), 32'h0);
  endtask

  initial begin
    RESET      = 1'b1;
    INSTR_ACK  = 1'b0;
    INSTR_DATA = '0;
    EXEC_DONE  = 1'b0;
    FLAGS_WE   = 1'b0;
    FLAGS_IN   = '0;
    tick();
    check_reset_outputs("rst");

    // Scenario 1: first fetch jumps always to 0x20.
    RESET      = 1'b0;
    INSTR_ACK  = 1'b1;
    INSTR_DATA = 16'hF720;
    tick();
    check("s1_req",  32'(INSTR_REQ),  32'h1);
    check("s1_addr", 32'(INSTR_ADDR), 32'h0);
    tick();
    INSTR_ACK = 1'b0;
    check("s1_ir",   32'(IR),         32'hF720);
    check("s1_req_dec", 32'(INSTR_REQ), 32'h0);
    tick();
    check("s1_pc",   32'(PC),         32'h20);
    check("s1_jmp",  32'(JUMP_TAKEN), 32'h1);
    check("s1_ret",  32'(RETIRED),    32'h1);
    tick();
    check("s1_jmp_pulse", 32'(JUMP_TAKEN), 32'h0);
    check("s1_hold_pc",   32'(PC),         32'h20);

    // Scenario 2: flag2 clear; plain condition not taken, inverted taken.
    issue(16'hF240);
    check("s2a_pc",  32'(PC),         32'h21);
    check("s2a_jmp", 32'(JUMP_TAKEN), 32'h0);
    check("s2a_ret", 32'(RETIRED),    32'h2);
    issue(16'hFA40);
    check("s2b_pc",  32'(PC),         32'h40);
    check("s2b_jmp", 32'(JUMP_TAKEN), 32'h1);
    check("s2b_ret", 32'(RETIRED),    32'h3);

    // Scenario 3: datapath op with EXEC_DONE after 5 cycles; stray ACK ignored.
    issue(16'h3000);
    INSTR_ACK  = 1'b1;
    INSTR_DATA = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      check("s3_ev", 32'(EXEC_VALID), 32'h1);
      check("s3_pc_hold", 32'(PC), 32'h40);
      if (i == 4) EXEC_DONE = 1'b1;
      tick();
    end
    EXEC_DONE = 1'b0;
    INSTR_ACK = 1'b0;
    check("s3_pc",  32'(PC),         32'h41);
    check("s3_ev_off", 32'(EXEC_VALID), 32'h0);
    check("s3_req", 32'(INSTR_REQ),  32'h1);
    check("s3_ir",  32'(IR),         32'h3000);
    check("s3_ret", 32'(RETIRED),    32'h4);

    // Scenario 4: PC wraps from 0xFF to 0x00 on a datapath op.
    issue(16'hF7FF);
    check("s4_pc_ff", 32'(PC), 32'hFF);
    issue(16'h1234);
    check("s4_ev", 32'(EXEC_VALID), 32'h1);
    EXEC_DONE = 1'b1;
    tick();
    EXEC_DONE = 1'b0;
    check("s4_pc_wrap", 32'(PC),      32'h00);
    check("s4_ret",     32'(RETIRED), 32'h6);

    // Scenario 5: flag write in the jump's DECODE cycle is seen only afterwards.
    INSTR_ACK  = 1'b1;
    INSTR_DATA = 16'hF210;
    tick();
    INSTR_ACK = 1'b0;
    FLAGS_WE  = 1'b1;
    FLAGS_IN  = 7'h04;
    tick();
    FLAGS_WE = 1'b0;
    FLAGS_IN = '0;
    check("s5a_pc",  32'(PC),         32'h01);
    check("s5a_jmp", 32'(JUMP_TAKEN), 32'h0);
    issue(16'hF210);
    check("s5b_pc",  32'(PC),         32'h10);
    check("s5b_jmp", 32'(JUMP_TAKEN), 32'h1);
    check("s5b_ret", 32'(RETIRED),    32'h8);
    issue(16'hFF55);
    check("s5c_never_pc",  32'(PC),         32'h11);
    check("s5c_never_jmp", 32'(JUMP_TAKEN), 32'h0);

    // Scenario 6: HALT holds for 20 cycles regardless of ACK/DONE.
    issue(16'hE000);
    check("s6_pc",  32'(PC),      32'h11);
    check("s6_ret", 32'(RETIRED), 32'hA);
    INSTR_ACK  = 1'b1;
    INSTR_DATA = 16'hF7AA;
    EXEC_DONE  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("s6_halt_req", 32'({HALTED, INSTR_REQ}), 32'h2);
      tick();
    end
    INSTR_ACK = 1'b0;
    EXEC_DONE = 1'b0;
    check("s6_pc_hold",  32'(PC),      32'h11);
    check("s6_ret_hold", 32'(RETIRED), 32'hA);
    check("s6_ir_hold",  32'(IR),      32'hE000);

    // Scenario 7: reset leaves HALT, then asynchronous reset mid-EXEC.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    check("s7_req", 32'(INSTR_REQ), 32'h1);
    issue(16'hF733);
    check("s7_pc", 32'(PC), 32'h33);
    issue(16'h5000);
    check("s7_ev", 32'(EXEC_VALID), 32'h1);
    #2;
    EXEC_DONE = 1'b1;
    RESET     = 1'b1;
    #1;
    check_reset_outputs("s7_async");
    tick();
    RESET = 1'b0;
    tick();
    EXEC_DONE = 1'b0;
    check("s7_pc_after",  32'(PC),      32'h0);
    check("s7_ret_after", 32'(RETIRED), 32'h0);
    check("s7_req_after", 32'(INSTR_REQ), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
